// File: rtl/timer.sv
// rtl/timer.sv - 16-bit programmable interval timer with prescaler, auto-reload and level IRQ
//
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   cs    - chip select (F6xx decode)
//   we    - write enable, high = write
//   addr  - register select
//   din   - write data from the CPU
//   dout  - registered read data, valid the cycle after the access
//   irq   - level interrupt request, EXP & IE
//
// Register map: 0 CTRL {IE,ARLD,EN}, 1 STAT {RUN,EXP} (W1C EXP), 2 PRE,
// 3 RLD_L, 4 RLD_H, 5 CNT_L (captures high byte), 6 CNT_H (latched), 7 zero.

module timer #(
    parameter logic [7:0]  PRE_RST = 8'h00,
    parameter logic [15:0] RLD_RST = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    logic        en, arld, ie, exp_flag;
    logic [7:0]  pre, pre_cnt, cnt_hi_latch;
    logic [15:0] rld, cnt;

    logic        en_n, arld_n, ie_n, exp_n;
    logic [7:0]  pre_n, pre_cnt_n;
    logic [15:0] rld_n, cnt_n;

    logic        wr, rd, tick;

    assign wr   = cs & we;
    assign rd   = cs & ~we;
    assign tick = en && (pre_cnt == pre);

    // Processing order matters: the EXP clear comes first so that an expiry
    // in the same cycle wins, and the CTRL write comes last so it owns EN and
    // a start-load replaces whatever the tick would have done to cnt.
    always_comb begin
        en_n      = en;
        arld_n    = arld;
        ie_n      = ie;
        exp_n     = exp_flag;
        pre_n     = pre;
        rld_n     = rld;
        cnt_n     = cnt;
        pre_cnt_n = pre_cnt;

        if (wr && addr == 3'd1 && din[0]) begin
            exp_n = 1'b0;
        end

        if (en) begin
            // Plain 8-bit increment: if PRE was lowered below pre_cnt the
            // counter wraps through FF before matching again.
            pre_cnt_n = tick ? 8'h00 : pre_cnt + 8'h01;
        end

        if (tick) begin
            if (cnt != 16'h0000) begin
                cnt_n = cnt - 16'h0001;
            end else begin
                exp_n = 1'b1;
                if (arld) begin
                    cnt_n = rld;
                end else begin
                    en_n = 1'b0;
                end
            end
        end

        if (wr) begin
            case (addr)
                3'd0: begin
                    en_n   = din[0];
                    arld_n = din[1];
                    ie_n   = din[2];
                    if (din[0] && !en) begin
                        cnt_n     = rld;
                        pre_cnt_n = 8'h00;
                    end else if (!din[0]) begin
                        // Stopping freezes cnt: no decrement, no reload.
                        cnt_n = cnt;
                    end
                end
                3'd2:    pre_n        = din;
                3'd3:    rld_n[7:0]   = din;
                3'd4:    rld_n[15:8]  = din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en           <= 1'b0;
            arld         <= 1'b0;
            ie           <= 1'b0;
            exp_flag     <= 1'b0;
            pre          <= PRE_RST;
            rld          <= RLD_RST;
            cnt          <= 16'h0000;
            pre_cnt      <= 8'h00;
            cnt_hi_latch <= 8'h00;
            dout         <= 8'h00;
            irq          <= 1'b0;
        end else begin
            en       <= en_n;
            arld     <= arld_n;
            ie       <= ie_n;
            exp_flag <= exp_n;
            pre      <= pre_n;
            rld      <= rld_n;
            cnt      <= cnt_n;
            pre_cnt  <= pre_cnt_n;
            // Built from next state so irq rises on the same edge as EXP.
            irq      <= exp_n & ie_n;

            if (rd) begin
                case (addr)
                    3'd0:    dout <= {5'b0, ie, arld, en};
                    3'd1:    dout <= {6'b0, en, exp_flag};
                    3'd2:    dout <= pre;
                    3'd3:    dout <= rld[7:0];
                    3'd4:    dout <= rld[15:8];
                    3'd5:    dout <= cnt[7:0];
                    3'd6:    dout <= cnt_hi_latch;
                    default: dout <= 8'h00;
                endcase
                // Capture the high byte with the low byte so a CNT_L/CNT_H
                // pair is never torn by a borrow between the two reads.
                if (addr == 3'd5) begin
                    cnt_hi_latch <= cnt[15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - self-checking bench for timer

module tb_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq;

    int checks = 0;
    int failures = 0;

    timer dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] expv;
    } vec_t;

    vec_t rst_tab[8];
    vec_t reg_tab[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Bus tasks are entered just after a negedge; the access lands on the
    // following posedge and the task returns on the next negedge.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_table(input string tag, input vec_t tab[], input int n);
        logic [7:0] rdv;
        for (int i = 0; i < n; i++) begin
            if (tab[i].wr) begin
                bus_write(tab[i].a, tab[i].d);
            end else begin
                bus_read(tab[i].a, rdv);
                check($sformatf("%s[%0d] addr%0d", tag, i, tab[i].a), {8'h00, rdv}, {8'h00, tab[i].expv});
            end
        end
    endtask

    logic [7:0] rv, rv2;

    initial begin
        rst_tab[0] = '{1'b0, 3'd0, 8'h00, 8'h00};
        rst_tab[1] = '{1'b0, 3'd1, 8'h00, 8'h00};
        rst_tab[2] = '{1'b0, 3'd2, 8'h00, 8'h00};
        rst_tab[3] = '{1'b0, 3'd3, 8'h00, 8'hFF};
        rst_tab[4] = '{1'b0, 3'd4, 8'h00, 8'hFF};
        rst_tab[5] = '{1'b0, 3'd5, 8'h00, 8'h00};
        rst_tab[6] = '{1'b0, 3'd6, 8'h00, 8'h00};
        rst_tab[7] = '{1'b0, 3'd7, 8'h00, 8'h00};

        reg_tab[0]  = '{1'b1, 3'd2, 8'h5A, 8'h00};
        reg_tab[1]  = '{1'b0, 3'd2, 8'h00, 8'h5A};
        reg_tab[2]  = '{1'b1, 3'd3, 8'h34, 8'h00};
        reg_tab[3]  = '{1'b0, 3'd3, 8'h00, 8'h34};
        reg_tab[4]  = '{1'b1, 3'd4, 8'h12, 8'h00};
        reg_tab[5]  = '{1'b0, 3'd4, 8'h00, 8'h12};
        reg_tab[6]  = '{1'b1, 3'd5, 8'h77, 8'h00};
        reg_tab[7]  = '{1'b0, 3'd5, 8'h00, 8'h00};
        reg_tab[8]  = '{1'b1, 3'd6, 8'h66, 8'h00};
        reg_tab[9]  = '{1'b0, 3'd6, 8'h00, 8'h00};
        reg_tab[10] = '{1'b1, 3'd7, 8'hAA, 8'h00};
        reg_tab[11] = '{1'b0, 3'd7, 8'h00, 8'h00};
        reg_tab[12] = '{1'b1, 3'd0, 8'hF6, 8'h00};
        reg_tab[13] = '{1'b0, 3'd0, 8'h00, 8'h06};
        reg_tab[14] = '{1'b1, 3'd0, 8'h00, 8'h00};
        reg_tab[15] = '{1'b0, 3'd1, 8'h00, 8'h00};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_irq", {15'h0, irq}, 16'h0000);
        run_table("reset", rst_tab, 8);

        // Plain register access, ignored writes, upper CTRL bits
        run_table("regs", reg_tab, 16);

        // One-shot: (4+1)*(3+1) = 20 clocks to expiry
        bus_write(3'd2, 8'h03);
        bus_write(3'd3, 8'h04);
        bus_write(3'd4, 8'h00);
        bus_write(3'd0, 8'h05);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 19) check("oneshot_irq_at19", {15'h0, irq}, 16'h0000);
            if (i == 20) check("oneshot_irq_at20", {15'h0, irq}, 16'h0001);
        end
        bus_read(3'd1, rv); check("oneshot_stat", {8'h0, rv}, 16'h0001);
        bus_read(3'd0, rv); check("oneshot_ctrl", {8'h0, rv}, 16'h0004);
        idle(30);
        bus_read(3'd5, rv); bus_read(3'd6, rv2);
        check("oneshot_cnt", {rv2, rv}, 16'h0000);
        check("oneshot_irq_held", {15'h0, irq}, 16'h0001);

        // Auto-reload every 3 clocks
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h01);
        check("ar_cleared", {15'h0, irq}, 16'h0000);
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h02);
        bus_write(3'd4, 8'h00);
        bus_write(3'd0, 8'h07);
        @(negedge clk);
        @(negedge clk);
        check("ar_irq_at2", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        check("ar_irq_at3", {15'h0, irq}, 16'h0001);
        bus_write(3'd1, 8'h01);
        check("ar_w1c_drop", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        check("ar_irq_at5", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        check("ar_irq_at6", {15'h0, irq}, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        bus_write(3'd1, 8'h01);   // lands on the expiry edge
        check("ar_w1c_vs_set", {15'h0, irq}, 16'h0001);
        bus_read(3'd1, rv); check("ar_stat", {8'h0, rv}, 16'h0003);

        // Latched count readback across 0x0100 -> 0x00FF
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h01);
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h01);
        bus_write(3'd0, 8'h01);
        bus_read(3'd5, rv); bus_read(3'd6, rv2);
        check("latch_a", {rv2, rv}, 16'h0100);
        bus_write(3'd0, 8'h00);
        bus_write(3'd0, 8'h01);
        @(negedge clk);
        bus_read(3'd5, rv); bus_read(3'd6, rv2);
        check("latch_b", {rv2, rv}, 16'h00FF);
        bus_write(3'd0, 8'h00);

        // IE masking
        bus_write(3'd1, 8'h01);
        bus_write(3'd3, 8'h01);
        bus_write(3'd4, 8'h00);
        bus_write(3'd0, 8'h03);
        idle(4);
        check("mask_irq", {15'h0, irq}, 16'h0000);
        bus_read(3'd1, rv); check("mask_stat", {8'h0, rv}, 16'h0003);
        bus_write(3'd0, 8'h07);
        check("ie_set_irq", {15'h0, irq}, 16'h0001);
        bus_write(3'd0, 8'h03);
        check("ie_clr_irq", {15'h0, irq}, 16'h0000);
        bus_read(3'd1, rv); check("ie_clr_stat", {8'h0, rv}, 16'h0003);

        // Stop mid-count: PRE=0F, start at 0x1000, one tick before stop
        bus_write(3'd0, 8'h00);
        bus_write(3'd2, 8'h0F);
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h10);
        bus_write(3'd0, 8'h01);
        idle(19);
        bus_write(3'd0, 8'h00);
        idle(50);
        bus_read(3'd5, rv); bus_read(3'd6, rv2);
        check("stop_frozen", {rv2, rv}, 16'h0FFF);

        // Reset mid-operation
        bus_write(3'd1, 8'h01);
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h02);
        bus_write(3'd4, 8'h00);
        bus_write(3'd0, 8'h07);
        idle(3);
        check("pre_rst_irq", {15'h0, irq}, 16'h0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_irq", {15'h0, irq}, 16'h0000);
        run_table("rst_mid", rst_tab, 8);
        idle(5);
        check("rst_mid_idle_irq", {15'h0, irq}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
